smart_appliances_sequencer: RTL
===============================

// Module: smart_appliances_sequencer
// PURPOSE
//  Parametrised successor to the fixed five-appliance controller. Drives NUM_APPL on/off status lines
//  from per-appliance command bits and enforces a whole-house power budget (at most MAX_ACTIVE on at once).
//  Enforces anti-short-cycle minimum on/off times per appliance and arbitrates waiting appliances round-robin.
//  Sits between the home-automation command decoder and the appliance relay drivers.
// PARAMETERS
//  NUM_APPL    5  number of appliance channels (>=2)
//  MAX_ACTIVE  3  max appliances simultaneously ON (1..NUM_APPL)
//  MIN_ON_CYC  4  minimum cycles an appliance stays ON once granted (>=1)
//  MIN_OFF_CYC 4  cooldown cycles after switching OFF before it may re-request (>=1)
// PORTS
//  clk           in   1                  system clock, rising edge
//  rst           in   1                  asynchronous, active-low reset (asserted when 0)
//  cmd           in   NUM_APPL           per-appliance on-request, level, synchronous to clk
//  status        out  NUM_APPL           1 = appliance powered (channel state ON), registered
//  pending       out  NUM_APPL           1 = channel waiting for budget grant (state REQ), registered
//  active_count  out  $clog2(NUM_APPL+1) number of channels currently ON
// BEHAVIOUR
//  - Reset (rst=0, async): all channels OFF, timers 0, RR pointer 0; status=0, pending=0, active_count=0.
//    Reset mid-operation drops every status immediately, without waiting for MIN_ON_CYC.
//  - Per-channel FSM (OFF, REQ, ON, COOL), one down-counter per channel, width $clog2(max(MIN_ON,MIN_OFF)+1):
//    OFF : cmd=1 -> REQ.
//    REQ : grant -> ON, timer<=MIN_ON_CYC-1. cmd=0 without grant -> OFF; no cooldown, never powered.
//    ON  : timer decrements to 0 and saturates. Exit only when timer==0 and cmd==0 -> COOL, timer<=MIN_OFF_CYC-1.
//          A cmd drop before min on-time keeps the channel ON until the timer expires.
//    COOL: timer decrements. At timer==0 -> REQ if cmd=1, else OFF. cmd is ignored while timer>0.
//  - Arbiter, combinational on registered state:
//    at most one grant per cycle, only if active_count < MAX_ACTIVE;
//    scans REQ channels starting at RR pointer; after a grant, pointer <= (granted+1) mod NUM_APPL, wrap-around.
//  - Latency: cmd sampled high at edge k -> REQ after k -> ON (status=1) after edge k+1 if budget free.
//  - Simultaneous ON->COOL exit and grant in one cycle: the grant uses the pre-edge active_count,
//    so a freed slot becomes usable the following cycle. active_count never exceeds MAX_ACTIVE.
//  - active_count = popcount of ON states, registered alongside the FSMs and always consistent with status.
// STRUCTURE
//  - Package home_auto_pkg: appl_state_e enum (OFF=2'b00, REQ=2'b01, ON=2'b10, COOL=2'b11)
//    and a clog2-based width helper constant function.
//  - Sub-module appliance_channel_fsm: one channel's FSM and timer. Inputs cmd, grant; outputs state, is_on, is_req.
//    Generated NUM_APPL times.
//  - Top level holds the round-robin arbiter, pointer register and active_count popcount register.
// TESTING (defaults N=5, MAX=3, MIN_ON=4, MIN_OFF=4)
//  1. Hold rst=0 for 3 cycles with cmd=5'b11111 -> status=0, pending=0, active_count=0 throughout.
//  2. cmd=5'b00001 at cycle 0 -> pending[0]=1 at cycle 1; status[0]=1 and active_count=1 at cycle 2.
//  3. cmd=5'b11111 from idle -> status goes 00001, 00011, 00111 on consecutive cycles;
//     pending=5'b11000 thereafter; active_count stays 3.
//  4. cmd[0] pulsed 1 cycle -> status[0] high exactly 4 cycles, then 4 cycles COOL.
//     Re-asserting cmd[0] during COOL -> REQ after cooldown, ON one cycle later.
//  5. From scenario 3 (pointer=3), drop cmd[1] -> ch1 turns OFF once min on-time is met; next cycle ch3 is granted.
//     ch4 stays pending (round-robin order).
//  6. Assert rst=0 asynchronously mid-cycle while 3 channels ON -> status=0 and active_count=0 before the next clk edge.

Source files
------------

// File: rtl/home_auto_pkg.sv
// Shared types and helpers for the home-automation appliance sequencer.
package home_auto_pkg;

    // Per-channel lifecycle: idle, waiting for budget, powered, cooling down.
    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_REQ  = 2'b01,
        ST_ON   = 2'b10,
        ST_COOL = 2'b11
    } appl_state_e;

    // Bits needed to hold values 0..max_value (always at least 1).
    function automatic int width_for(input int max_value);
        int w;
        w = 1;
        while ((1 << w) <= max_value) begin
            w++;
        end
        return w;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/appliance_channel_fsm.sv
// One appliance channel: request / power / cooldown FSM with a shared
// down-counter enforcing minimum on-time and minimum off-time.
module appliance_channel_fsm
    import home_auto_pkg::*;
#(
    parameter int MIN_ON_CYC  = 4,
    parameter int MIN_OFF_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd,
    input  logic        grant,
    output appl_state_e state,
    output logic        is_on,
    output logic        is_req,
    output logic        on_next
);

    localparam int TW = width_for(max2(MIN_ON_CYC, MIN_OFF_CYC));
    localparam logic [TW-1:0] ON_LOAD  = TW'(MIN_ON_CYC - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(MIN_OFF_CYC - 1);

    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    appl_state_e   state_next;

    // Next-state and timer decisions; grant is only ever given while in REQ.
    always_comb begin
        state_next = state;
        timer_next = timer;
        case (state)
            ST_OFF: begin
                if (cmd) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (grant) begin
                    state_next = ST_ON;
                    timer_next = ON_LOAD;
                end else if (!cmd) begin
                    state_next = ST_OFF;
                end
            end
            ST_ON: begin
                // Timer saturates at 0; a dropped cmd only takes effect once expired.
                if (timer != '0) begin
                    timer_next = timer - 1'b1;
                end else if (!cmd) begin
                    state_next = ST_COOL;
                    timer_next = OFF_LOAD;
                end
            end
            ST_COOL: begin
                // cmd is ignored until the cooldown has fully elapsed.
                if (timer != '0) begin
                    timer_next = timer - 1'b1;
                end else begin
                    state_next = cmd ? ST_REQ : ST_OFF;
                end
            end
            default: begin
                state_next = ST_OFF;
            end
        endcase
    end

    // The top-level popcount needs to know whether this channel is ON after the edge.
    assign on_next = (state_next == ST_ON);

    // State, timer and decoded status flags, all registered together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_OFF;
            timer  <= '0;
            is_on  <= 1'b0;
            is_req <= 1'b0;
        end else begin
            state  <= state_next;
            timer  <= timer_next;
            is_on  <= (state_next == ST_ON);
            is_req <= (state_next == ST_REQ);
        end
    end

endmodule

// File: rtl/smart_appliances_sequencer.sv
// Whole-house appliance sequencer: per-channel FSMs plus a round-robin
// arbiter that grants at most one waiting channel per cycle while the
// number of powered channels is below the power budget.
module smart_appliances_sequencer
    import home_auto_pkg::*;
#(
    parameter int NUM_APPL    = 5,
    parameter int MAX_ACTIVE  = 3,
    parameter int MIN_ON_CYC  = 4,
    parameter int MIN_OFF_CYC = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_APPL-1:0]             cmd,
    output logic [NUM_APPL-1:0]             status,
    output logic [NUM_APPL-1:0]             pending,
    output logic [$clog2(NUM_APPL+1)-1:0]   active_count
);

    localparam int CW = $clog2(NUM_APPL + 1);
    localparam int PW = width_for(NUM_APPL - 1);
    localparam logic [CW-1:0] BUDGET = CW'(MAX_ACTIVE);

    appl_state_e          chan_state [NUM_APPL];
    logic [NUM_APPL-1:0]  req_vec;
    logic [NUM_APPL-1:0]  on_next_vec;
    logic [NUM_APPL-1:0]  grant;
    logic                 grant_valid;
    logic [PW-1:0]        grant_idx;
    logic [PW-1:0]        rr_ptr;
    logic [CW-1:0]        count_next;

    genvar g;
    generate
        for (g = 0; g < NUM_APPL; g++) begin : gen_chan
            appliance_channel_fsm #(
                .MIN_ON_CYC  (MIN_ON_CYC),
                .MIN_OFF_CYC (MIN_OFF_CYC)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .cmd     (cmd[g]),
                .grant   (grant[g]),
                .state   (chan_state[g]),
                .is_on   (status[g]),
                .is_req  (pending[g]),
                .on_next (on_next_vec[g])
            );
            assign req_vec[g] = (chan_state[g] == ST_REQ);
        end
    endgenerate

    // Round-robin pick of the first REQ channel at or after rr_ptr, budget permitting.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant       = '0;
        if (active_count < BUDGET) begin
            for (int i = 0; i < NUM_APPL; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= NUM_APPL) begin
                    idx = idx - NUM_APPL;
                end
                if (!grant_valid && req_vec[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = PW'(idx);
                end
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Count of channels that will be ON after this edge.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < NUM_APPL; i++) begin
            count_next = count_next + CW'(on_next_vec[i]);
        end
    end

    // Pointer moves just past the granted channel, wrapping at NUM_APPL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= (int'(grant_idx) == NUM_APPL - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // Active count registered alongside the channel states so it always matches status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_count <= '0;
        end else begin
            active_count <= count_next;
        end
    end

endmodule
